// File: rtl/rstreq_pkg.sv
// rtl/rstreq_pkg.sv - shared types and constants for the reset request generator
//
// Purpose: FSM state encoding and rst_cause code values used by
//          reset_request_gen and its testbench.
// Ports:   none (package)
package rstreq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ASSERT = 2'd1,
    HOLD   = 2'd2
  } state_t;

  localparam logic [1:0] CAUSE_NONE = 2'b00;
  localparam logic [1:0] CAUSE_BTN  = 2'b01;
  localparam logic [1:0] CAUSE_WDT  = 2'b10;
  localparam logic [1:0] CAUSE_BOTH = 2'b11;

endpackage

// File: rtl/rstreq_debounce.sv
// rtl/rstreq_debounce.sv - button synchronizer and debounce counter
//
// Purpose: brings the raw asynchronous push-button into the clk domain and
//          accepts a new level only after DEBOUNCE_CYCLES consecutive
//          identical synchronized samples.
// Ports:
//   clk        in   board clock
//   resetn     in   asynchronous active-low power-on reset
//   btn_raw    in   raw bouncy button, active high
//   btn_level  out  debounced button level
//   btn_evt    out  single-cycle pulse on a btn_level 0->1 transition
module rstreq_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 26
) (
  input  logic clk,
  input  logic resetn,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_evt
);

  logic             sync1;
  logic             sync2;
  logic             level_q;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      level_q   <= 1'b0;
      btn_level <= 1'b0;
      cnt       <= '0;
    end else begin
      sync1   <= btn_raw;
      sync2   <= sync1;
      level_q <= btn_level;
      // Any sample matching the current level restarts the run, so only an
      // unbroken run of DEBOUNCE_CYCLES differing samples flips the level.
      if (sync2 != btn_level) begin
        if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          btn_level <= ~btn_level;
          cnt       <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  // Edge detect against the previous level: the event is visible in the
  // cycle after btn_level rises, giving the FSM a one-cycle request latency.
  assign btn_evt = btn_level & ~level_q;

endmodule

// File: rtl/reset_request_gen.sv
// rtl/reset_request_gen.sv - board-level reset request pulse generator
//
// Purpose: turns a debounced button press or a software watchdog timeout
//          into a clean active-high rst_req pulse of PULSE_CYCLES cycles and
//          records a sticky cause code. Its own reset is power-on only.
// Configuration: define RSTREQ_WDT_EN to build the watchdog; otherwise
//          wdt_en/wdt_kick are ignored and rst_cause[1] is constant 0.
// Ports:
//   clk        in   board clock
//   resetn     in   asynchronous active-low power-on reset
//   btn_raw    in   raw bouncy button, active high
//   wdt_en     in   watchdog armed while high
//   wdt_kick   in   single-cycle pulse restarting the watchdog count
//   rst_req    out  active-high reset request
//   rst_cause  out  sticky cause: 00 none, 01 button, 10 watchdog, 11 both
//   btn_level  out  debounced button level
module reset_request_gen
  import rstreq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int PULSE_CYCLES    = 16,
  parameter int WDT_CYCLES      = 2**24,
  parameter int CNT_W           = 26
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       btn_raw,
  input  logic       wdt_en,
  input  logic       wdt_kick,
  output logic       rst_req,
  output logic [1:0] rst_cause,
  output logic       btn_level
);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] pulse_cnt;
  logic [CNT_W-1:0] pulse_cnt_nxt;
  logic [1:0]       cause_nxt;
  logic             rst_req_nxt;
  logic             btn_evt;
  logic             wdt_evt;

  rstreq_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_debounce (
    .clk       (clk),
    .resetn    (resetn),
    .btn_raw   (btn_raw),
    .btn_level (btn_level),
    .btn_evt   (btn_evt)
  );

`ifdef RSTREQ_WDT_EN
  logic [CNT_W-1:0] wdt_cnt;
  logic             wdt_terminal;

  assign wdt_terminal = (wdt_cnt == CNT_W'(WDT_CYCLES - 1));
  // A kick landing in the terminal cycle suppresses the timeout.
  assign wdt_evt = (state == IDLE) && wdt_en && !wdt_kick && wdt_terminal;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wdt_cnt <= '0;
    end else if ((state != IDLE) || !wdt_en || wdt_kick || wdt_terminal) begin
      wdt_cnt <= '0;
    end else begin
      wdt_cnt <= wdt_cnt + 1'b1;
    end
  end
`else
  logic unused_wdt;

  assign wdt_evt    = 1'b0;
  assign unused_wdt = wdt_en ^ wdt_kick ^ (WDT_CYCLES > 1);
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      pulse_cnt <= '0;
      rst_cause <= CAUSE_NONE;
      rst_req   <= 1'b0;
    end else begin
      state     <= state_nxt;
      pulse_cnt <= pulse_cnt_nxt;
      rst_cause <= cause_nxt;
      rst_req   <= rst_req_nxt;
    end
  end

  // rst_req is its own flop (not a state decode) so the request line cannot
  // glitch while the state bits change.
  always_comb begin
    state_nxt     = state;
    pulse_cnt_nxt = pulse_cnt;
    cause_nxt     = rst_cause;
    rst_req_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (btn_evt || wdt_evt) begin
          state_nxt     = ASSERT;
          pulse_cnt_nxt = '0;
          cause_nxt     = {wdt_evt, btn_evt};
          rst_req_nxt   = 1'b1;
        end
      end
      ASSERT: begin
        if (pulse_cnt == CNT_W'(PULSE_CYCLES - 1)) begin
          state_nxt = HOLD;
        end else begin
          pulse_cnt_nxt = pulse_cnt + 1'b1;
          rst_req_nxt   = 1'b1;
        end
      end
      HOLD: begin
        // A button still held after the pulse must be released before
        // another request can be taken.
        if (!btn_level) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_reset_request_gen.sv
// tb/tb_reset_request_gen.sv - self-checking bench for reset_request_gen
module tb_reset_request_gen;
  import rstreq_pkg::*;

  localparam int DEB = 4;
  localparam int PUL = 3;
  localparam int WDT = 10;
  localparam int CW  = 26;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       btn_raw = 1'b0;
  logic       wdt_en = 1'b0;
  logic       wdt_kick = 1'b0;
  logic       rst_req;
  logic [1:0] rst_cause;
  logic       btn_level;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int         width;
    logic [1:0] cause;
  } pulse_t;

  pulse_t exp_q[$];
  pulse_t obs_q[$];
  pulse_t mon_p;
  int     mon_width = 0;

  always #5 clk = ~clk;

  reset_request_gen #(
    .DEBOUNCE_CYCLES (DEB),
    .PULSE_CYCLES    (PUL),
    .WDT_CYCLES      (WDT),
    .CNT_W           (CW)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .btn_raw   (btn_raw),
    .wdt_en    (wdt_en),
    .wdt_kick  (wdt_kick),
    .rst_req   (rst_req),
    .rst_cause (rst_cause),
    .btn_level (btn_level)
  );

  // Pulse monitor: records each completed rst_req pulse (width, cause).
  always @(negedge clk) begin
    if (!resetn) begin
      mon_width = 0;
    end else if (rst_req) begin
      mon_width++;
    end else if (mon_width > 0) begin
      mon_p.width = mon_width;
      mon_p.cause = rst_cause;
      obs_q.push_back(mon_p);
      mon_width = 0;
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_pulse(input int width, input logic [1:0] cause);
    pulse_t p;
    p.width = width;
    p.cause = cause;
    exp_q.push_back(p);
  endtask

  task automatic score(input string tag);
    pulse_t e;
    pulse_t o;
    check({tag, "_count"}, obs_q.size(), exp_q.size());
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      check({tag, "_width"}, o.width, e.width);
      check({tag, "_cause"}, o.cause, e.cause);
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  initial begin
    int   n;
    logic seen;

    // Reset state
    tick(3);
    check("reset_req", rst_req, 0);
    check("reset_cause", rst_cause, CAUSE_NONE);
    check("reset_level", btn_level, 0);
    check("reset_state", dut.state, IDLE);
    resetn = 1'b1;
    tick(2);

    // Bounce: toggle every 2 cycles for 20 cycles, level must not move
    for (int i = 0; i < 10; i++) begin
      btn_raw = ~btn_raw;
      tick(2);
      check("bounce_level", btn_level, 0);
    end
    btn_raw = 1'b1;
    expect_pulse(PUL, CAUSE_BTN);
    for (int k = 1; k <= 6; k++) begin
      tick(1);
      check("deb_level", btn_level, (k == 6));
    end
    check("req_before_rise", rst_req, 0);
    tick(1);
    check("req_rise", rst_req, 1);
    check("cause_btn", rst_cause, CAUSE_BTN);
    tick(2);
    check("req_third_cycle", rst_req, 1);
    tick(1);
    check("req_fall", rst_req, 0);
    check("state_hold", dut.state, HOLD);

    // Held button: no retrigger
    tick(50);
    check("held_state", dut.state, HOLD);
    score("btn_pulse");
    btn_raw = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick(1);
      check("release_level", btn_level, (k < 6));
    end
    check("release_state_hold", dut.state, HOLD);
    tick(1);
    check("release_state_idle", dut.state, IDLE);
    check("cause_sticky", rst_cause, CAUSE_BTN);

    // Mid-pulse reset
    btn_raw = 1'b1;
    tick(7);
    check("mid_req_cycle1", rst_req, 1);
    tick(1);
    check("mid_req_cycle2", rst_req, 1);
    resetn = 1'b0;
    #1;
    check("mid_req_async", rst_req, 0);
    check("mid_cause", rst_cause, CAUSE_NONE);
    check("mid_state", dut.state, IDLE);
    btn_raw = 1'b0;
    tick(2);
    resetn = 1'b1;
    tick(3);
    check("post_reset_state", dut.state, IDLE);
    check("post_reset_req", rst_req, 0);
    score("mid_reset");

`ifdef RSTREQ_WDT_EN
    // Watchdog timeout with no kicks
    expect_pulse(PUL, CAUSE_WDT);
    wdt_en = 1'b1;
    n = 0;
    do begin
      tick(1);
      n++;
    end while (!rst_req && n < 30);
    check("wdt_latency", n, 10);
    check("wdt_cause", rst_cause, CAUSE_WDT);
    tick(2);
    check("wdt_req_third", rst_req, 1);
    tick(1);
    check("wdt_req_fall", rst_req, 0);
    wdt_en = 1'b0;
    tick(3);
    score("wdt_pulse");
    check("wdt_state_idle", dut.state, IDLE);

    // Kick in the terminal cycle wins
    wdt_en = 1'b1;
    tick(9);
    wdt_kick = 1'b1;
    tick(1);
    wdt_kick = 1'b0;
    check("term_kick_req", rst_req, 0);
    tick(9);
    wdt_en = 1'b0;
    tick(2);
    check("term_kick_req_late", rst_req, 0);

    // Regular kicks every 8 cycles for 200 cycles
    wdt_en = 1'b1;
    for (int i = 0; i < 25; i++) begin
      wdt_kick = 1'b1;
      tick(1);
      wdt_kick = 1'b0;
      tick(7);
    end
    check("kick_req", rst_req, 0);
    wdt_en = 1'b0;
    tick(2);
    score("kick_pulses");

    // Button event aligned with watchdog terminal cycle
    expect_pulse(PUL, CAUSE_BOTH);
    wdt_en = 1'b1;
    tick(3);
    btn_raw = 1'b1;
    tick(7);
    check("both_req", rst_req, 1);
    check("both_cause", rst_cause, CAUSE_BOTH);
    tick(3);
    check("both_req_fall", rst_req, 0);
    wdt_en = 1'b0;
    btn_raw = 1'b0;
    tick(10);
    score("both_pulse");
    check("both_state_idle", dut.state, IDLE);
`else
    // Watchdog absent: enable without kicks never requests
    wdt_en = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      seen = seen | rst_req | rst_cause[1];
    end
    check("nowdt_seen", seen, 0);
    check("nowdt_cause1", rst_cause[1], 0);
    wdt_en = 1'b0;
    tick(2);
    score("nowdt_pulses");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
